// File: rtl/bram_arb_pkg.sv
// Shared constants and types for the dual-port BRAM arbiter.
// Holds the default geometry, the port-id width helper and the pending-response record.
package bram_arb_pkg;

  localparam int BRAM_ADDR_W = 10;
  localparam int BRAM_DATA_W = 16;
  localparam int MAX_NREQ    = 8;
  localparam int MAX_ID_W    = 3;

  // Requester-index width; never narrower than one bit even for two requesters.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } pend_t;

endpackage

// File: rtl/bram_arb_rr_pick.sv
// Round-robin picker: finds the first and second set bits of a request vector,
// scanning upward from a start index and wrapping modulo N.
module bram_arb_rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   i_vec,
  input  logic [IDW-1:0] i_start,
  output logic [IDW-1:0] o_first_idx,
  output logic           o_first_found,
  output logic [IDW-1:0] o_second_idx,
  output logic           o_second_found
);

  // NOTE: every output gets a default before the scan so no path leaves a latch.
  always_comb begin
    o_first_idx    = '0;
    o_first_found  = 1'b0;
    o_second_idx   = '0;
    o_second_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (int'(i_start) + k) % N;
      if (i_vec[idx]) begin
        if (!o_first_found) begin
          o_first_found = 1'b1;
          o_first_idx   = IDW'(idx);
        end else if (!o_second_found) begin
          o_second_found = 1'b1;
          o_second_idx   = IDW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/bram_1024x16_arbiter.sv
// Shares both ports of a 1024x16 dual-port BRAM among NREQ requesters with
// round-robin grants, write/address collision blocking and 1-cycle read return.
module bram_1024x16_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int ADDR_W = BRAM_ADDR_W,
  parameter int DATA_W = BRAM_DATA_W
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [NREQ*DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0]      A0,
  output logic [ADDR_W-1:0]      A1,
  output logic [DATA_W-1:0]      D0,
  output logic [DATA_W-1:0]      D1,
  output logic                   WE0,
  output logic                   WE1,
  output logic                   CE0,
  output logic                   CE1,
  input  logic [DATA_W-1:0]      Q0,
  input  logic [DATA_W-1:0]      Q1
);

  localparam int ID_W = id_width(NREQ);

  logic [ID_W-1:0]   r_rr_ptr;
  pend_t             r_pend0;
  pend_t             r_pend1;

  logic [ADDR_W-1:0] w_addr  [NREQ];
  logic [DATA_W-1:0] w_wdata [NREQ];
  logic [ID_W-1:0]   w_first_idx;
  logic [ID_W-1:0]   w_second_idx;
  logic              w_first_found;
  logic              w_second_found;
  logic              w_collide;
  logic              w_g0;
  logic              w_g1;
  logic [ID_W-1:0]   w_last;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_addr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign w_wdata[gi] = req_wdata[gi*DATA_W +: DATA_W];
  end

  bram_arb_rr_pick #(
    .N   (NREQ),
    .IDW (ID_W)
  ) u_pick (
    .i_vec          (req_valid),
    .i_start        (r_rr_ptr),
    .o_first_idx    (w_first_idx),
    .o_first_found  (w_first_found),
    .o_second_idx   (w_second_idx),
    .o_second_found (w_second_found)
  );

  // Two reads of one address are harmless; any write to a shared address defers port 1.
  assign w_collide = w_second_found
                   && (w_addr[w_first_idx] == w_addr[w_second_idx])
                   && (req_we[w_first_idx] || req_we[w_second_idx]);
  assign w_g0      = w_first_found;
  assign w_g1      = w_second_found && !w_collide;
  assign w_last    = w_g1 ? w_second_idx : w_first_idx;

  always_comb begin
    req_ready = '0;
    CE0 = 1'b0;  WE0 = 1'b0;  A0 = '0;  D0 = '0;
    CE1 = 1'b0;  WE1 = 1'b0;  A1 = '0;  D1 = '0;
    if (w_g0) begin
      req_ready[w_first_idx] = 1'b1;
      CE0 = 1'b1;
      WE0 = req_we[w_first_idx];
      A0  = w_addr[w_first_idx];
      D0  = w_wdata[w_first_idx];
    end
    if (w_g1) begin
      req_ready[w_second_idx] = 1'b1;
      CE1 = 1'b1;
      WE1 = req_we[w_second_idx];
      A1  = w_addr[w_second_idx];
      D1  = w_wdata[w_second_idx];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_rr_ptr <= '0;
      r_pend0  <= '0;
      r_pend1  <= '0;
    end else begin
      if (w_g0) begin
        r_rr_ptr <= (w_last == ID_W'(NREQ - 1)) ? '0 : w_last + ID_W'(1);
      end
      r_pend0.valid <= w_g0 && !req_we[w_first_idx];
      r_pend0.id    <= MAX_ID_W'(w_first_idx);
      r_pend1.valid <= w_g1 && !req_we[w_second_idx];
      r_pend1.id    <= MAX_ID_W'(w_second_idx);
    end
  end

  // Read data passes straight from the BRAM output to whichever requester owns the port.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_pend0.valid && (r_pend0.id == MAX_ID_W'(i))) begin
        rsp_valid[i]                  = 1'b1;
        rsp_rdata[i*DATA_W +: DATA_W] = Q0;
      end
      if (r_pend1.valid && (r_pend1.id == MAX_ID_W'(i))) begin
        rsp_valid[i]                  = 1'b1;
        rsp_rdata[i*DATA_W +: DATA_W] = Q1;
      end
    end
  end

endmodule
